// File: rtl/ps2_code_decoder.sv
// PS/2 scan-code decoder: turns the receiver's byte stream into make/break key
// events with extended/pause qualifiers, tracks modifiers, and buffers events in a FWFT FIFO.
module ps2_code_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       NEW_CODE,
  input  logic [7:0] CODE,
  output logic       EV_VALID,
  input  logic       EV_READY,
  output logic [7:0] EV_CODE,
  output logic       EV_BREAK,
  output logic       EV_EXT,
  output logic       EV_PAUSE,
  output logic [3:0] MODS,
  output logic       DEV_MSG,
  output logic       OVERFLOW
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE
  } state_t;

  state_t      state_q, state_d, eff;
  logic [2:0]  skip_q, skip_d;
  logic        emit, e_brk, e_ext, e_pause, is_dev, dev_d;
  logic [7:0]  ev_code;
  logic        dev_q, ovf_q;
  // {ralt, lalt, rctrl, lctrl, rshift, lshift}
  logic [5:0]  held_q, held_d;
  logic        caps_held_q, caps_held_d, caps_q, caps_d;

  logic [10:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        full, empty, push, pop;
  logic [10:0] head;

  always_comb begin
    is_dev  = CODE inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    state_d = state_q;
    skip_d  = skip_q;
    eff     = state_q;
    emit    = 1'b0;
    e_brk   = 1'b0;
    e_ext   = 1'b0;
    e_pause = 1'b0;
    dev_d   = 1'b0;
    if (NEW_CODE) begin
      if (state_q == S_PAUSE) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          emit    = 1'b1;
          e_pause = 1'b1;
          e_ext   = 1'b1;
          state_d = S_IDLE;
        end
      end else if (is_dev) begin
        dev_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        // A fresh prefix after a pending F0 restarts decoding from IDLE.
        if ((state_q == S_BRK || state_q == S_EXT_BRK) &&
            (CODE inside {8'hE0, 8'hE1, 8'hF0}))
          eff = S_IDLE;
        case (eff)
          S_EXT: begin
            if (CODE == 8'hF0)      state_d = S_EXT_BRK;
            else if (CODE == 8'hE0) state_d = S_EXT;
            else begin
              emit    = 1'b1;
              e_ext   = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            emit    = 1'b1;
            e_brk   = 1'b1;
            e_ext   = (eff == S_EXT_BRK);
            state_d = S_IDLE;
          end
          default: begin
            if (CODE == 8'hE0)      state_d = S_EXT;
            else if (CODE == 8'hF0) state_d = S_BRK;
            else if (CODE == 8'hE1) begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end else begin
              emit    = 1'b1;
              state_d = S_IDLE;
            end
          end
        endcase
        if (emit && e_ext && (CODE == 8'h12 || CODE == 8'h59))
          emit = 1'b0;
      end
    end
    ev_code = e_pause ? 8'h77 : CODE;
  end

  always_comb begin
    held_d      = held_q;
    caps_held_d = caps_held_q;
    caps_d      = caps_q;
    if (emit && !e_pause) begin
      case ({e_ext, CODE})
        9'h012:  held_d[0] = !e_brk;
        9'h059:  held_d[1] = !e_brk;
        9'h014:  held_d[2] = !e_brk;
        9'h114:  held_d[3] = !e_brk;
        9'h011:  held_d[4] = !e_brk;
        9'h111:  held_d[5] = !e_brk;
        default: ;
      endcase
      if (CODE == 8'h58) begin
        if (e_brk) caps_held_d = 1'b0;
        else begin
          if (!caps_held_q) caps_d = !caps_q;
          caps_held_d = 1'b1;
        end
      end
    end
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && EV_READY;
  assign push  = emit && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {e_pause, e_ext, e_brk, ev_code};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      skip_q      <= '0;
      held_q      <= '0;
      caps_held_q <= 1'b0;
      caps_q      <= 1'b0;
      dev_q       <= 1'b0;
      ovf_q       <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      held_q      <= held_d;
      caps_held_q <= caps_held_d;
      caps_q      <= caps_d;
      dev_q       <= dev_d;
      if (emit && full && !pop) ovf_q <= 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  assign head     = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign EV_VALID = !empty;
  assign EV_PAUSE = head[10];
  assign EV_EXT   = head[9];
  assign EV_BREAK = head[8];
  assign EV_CODE  = head[7:0];
  assign MODS     = {caps_q, |held_q[5:4], |held_q[3:2], |held_q[1:0]};
  assign DEV_MSG  = dev_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_ps2_code_decoder.sv
// Bench for ps2_code_decoder: directed test-plan sequences plus random byte streams,
// all checked every cycle against a prefix/queue model of the decoding rules.
module tb_ps2_code_decoder;
  localparam int unsigned D = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       NEW_CODE = 1'b0;
  logic [7:0] CODE = '0;
  logic       EV_READY = 1'b0;
  logic       EV_VALID, EV_BREAK, EV_EXT, EV_PAUSE, DEV_MSG, OVERFLOW;
  logic [7:0] EV_CODE;
  logic [3:0] MODS;

  ps2_code_decoder #(.FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .NEW_CODE(NEW_CODE), .CODE(CODE),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_CODE(EV_CODE),
    .EV_BREAK(EV_BREAK), .EV_EXT(EV_EXT), .EV_PAUSE(EV_PAUSE),
    .MODS(MODS), .DEV_MSG(DEV_MSG), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Model: pending-prefix flags, pause byte countdown, event queue, modifier bits.
  logic [10:0] mq[$];
  bit  pend_ext, pend_brk, mdev, movf;
  int  skip_left;
  bit  lsh, rsh, lct, rct, lal, ral, caps_held, caps;

  function automatic logic [3:0] mmods();
    return {caps, lal | ral, lct | rct, lsh | rsh};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend_ext = 0; pend_brk = 0; mdev = 0; movf = 0; skip_left = 0;
    lsh = 0; rsh = 0; lct = 0; rct = 0; lal = 0; ral = 0; caps_held = 0; caps = 0;
  endtask

  task automatic model_step();
    bit          pop_now, full_b, ev;
    logic [10:0] e;
    logic [7:0]  b;
    pop_now = (mq.size() > 0) && EV_READY;
    full_b  = (mq.size() == D);
    ev = 0; e = '0; b = CODE;
    mdev = 0;
    if (pop_now) void'(mq.pop_front());
    if (NEW_CODE) begin
      if (skip_left > 0) begin
        skip_left--;
        if (skip_left == 0) begin ev = 1; e = {1'b1, 1'b1, 1'b0, 8'h77}; end
      end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
        mdev = 1; pend_ext = 0; pend_brk = 0;
      end else if (b == 8'hE0) begin
        pend_brk = 0; pend_ext = 1;
      end else if (b == 8'hF0) begin
        if (pend_brk) pend_ext = 0;
        pend_brk = 1;
      end else if (b == 8'hE1) begin
        if (pend_ext && !pend_brk) begin ev = 1; e = {1'b0, 1'b1, 1'b0, b}; end
        else skip_left = 7;
        pend_ext = 0; pend_brk = 0;
      end else begin
        ev = 1; e = {1'b0, pend_ext, pend_brk, b};
        pend_ext = 0; pend_brk = 0;
      end
      if (ev && !e[10] && e[9] && (b == 8'h12 || b == 8'h59)) ev = 0;
    end
    if (ev) begin
      if (!e[10]) begin
        if (!e[9] && b == 8'h12) lsh = !e[8];
        if (!e[9] && b == 8'h59) rsh = !e[8];
        if (!e[9] && b == 8'h14) lct = !e[8];
        if ( e[9] && b == 8'h14) rct = !e[8];
        if (!e[9] && b == 8'h11) lal = !e[8];
        if ( e[9] && b == 8'h11) ral = !e[8];
        if (b == 8'h58) begin
          if (e[8]) caps_held = 0;
          else begin
            if (!caps_held) caps = !caps;
            caps_held = 1;
          end
        end
      end
      if (!full_b || pop_now) mq.push_back(e);
      else movf = 1;
    end
  endtask

  task automatic compare_all();
    logic [10:0] exph;
    exph = (mq.size() > 0) ? mq[0] : 11'h0;
    chk("valid", EV_VALID, mq.size() != 0);
    chk("head", {EV_PAUSE, EV_EXT, EV_BREAK, EV_CODE}, exph);
    chk("mods", MODS, mmods());
    chk("dev_msg", DEV_MSG, mdev);
    chk("overflow", OVERFLOW, movf);
  endtask

  // Called at a negedge; drives one cycle, steps the model at the edge, checks at next negedge.
  task automatic tick(input logic nc, input logic [7:0] c, input logic rdy);
    NEW_CODE = nc; CODE = c; EV_READY = rdy;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_outputs", {EV_VALID, EV_PAUSE, EV_EXT, EV_BREAK, EV_CODE, MODS, DEV_MSG, OVERFLOW}, '0);
    #1 RST = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic flush();
    for (int i = 0; i < D + 1; i++) tick(1'b0, 8'h00, 1'b1);
  endtask

  logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h14, 8'h11,
                            8'h58, 8'hAA, 8'h00, 8'h1C, 8'h77, 8'h7C, 8'hFA};

  initial begin
    logic [3:0] mods_snap;
    int n;
    logic [7:0] first;
    model_reset();
    repeat (2) @(negedge CLK);
    compare_all();
    chk("reset_valid", EV_VALID, 1'b0);
    RST = 1'b1;

    // make then break of 1C
    tick(1, 8'h1C, 1);
    chk("t1_make", {EV_VALID, EV_PAUSE, EV_EXT, EV_BREAK, EV_CODE}, {4'b1000, 8'h1C});
    tick(1, 8'hF0, 1);
    chk("t1_gap", EV_VALID, 1'b0);
    tick(1, 8'h1C, 1);
    chk("t1_break", {EV_VALID, EV_PAUSE, EV_EXT, EV_BREAK, EV_CODE}, {4'b1001, 8'h1C});
    flush();

    // modifiers
    tick(1, 8'hE0, 1); tick(1, 8'h14, 1); tick(1, 8'h12, 1);
    tick(1, 8'h59, 1); tick(1, 8'hF0, 1); tick(1, 8'h12, 1);
    chk("t2_mods_a", MODS, 4'b0011);
    tick(1, 8'hE0, 1); tick(1, 8'hF0, 1); tick(1, 8'h14, 1);
    chk("t2_mods_b", MODS, 4'b0001);
    tick(1, 8'hE0, 1); tick(1, 8'h75, 1);
    chk("t2_ext", {EV_VALID, EV_PAUSE, EV_EXT, EV_BREAK, EV_CODE}, {4'b1010, 8'h75});
    flush();

    // pause sequence, back-to-back
    mods_snap = MODS;
    tick(1, 8'hE1, 0); tick(1, 8'h14, 0); tick(1, 8'h77, 0); tick(1, 8'hE1, 0);
    tick(1, 8'hF0, 0); tick(1, 8'h14, 0); tick(1, 8'hF0, 0);
    chk("t3_none_yet", EV_VALID, 1'b0);
    tick(1, 8'h77, 0);
    chk("t3_pause", {EV_VALID, EV_PAUSE, EV_EXT, EV_BREAK, EV_CODE}, {4'b1110, 8'h77});
    chk("t3_mods", MODS, mods_snap);
    tick(0, 8'h00, 1);
    chk("t3_single", EV_VALID, 1'b0);

    // caps lock and fake shift
    tick(1, 8'h58, 1);
    chk("t4_caps_on", MODS[3], 1'b1);
    tick(1, 8'h58, 1); tick(1, 8'hF0, 1); tick(1, 8'h58, 1); tick(1, 8'h58, 1);
    chk("t4_caps_off", MODS[3], 1'b0);
    flush();
    tick(1, 8'hE0, 0); tick(1, 8'h12, 0); tick(1, 8'hE0, 0); tick(1, 8'h7C, 0);
    chk("t4_fake", {EV_VALID, EV_PAUSE, EV_EXT, EV_BREAK, EV_CODE}, {4'b1010, 8'h7C});
    tick(0, 8'h00, 1);
    chk("t4_only", EV_VALID, 1'b0);

    // overflow and ordered drain
    for (int i = 1; i <= 5; i++) tick(1, 8'(i), 0);
    chk("t5_ovf", OVERFLOW, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("t5_order", EV_CODE, 8'(i));
      tick(0, 8'h00, 1);
    end
    chk("t5_empty", EV_VALID, 1'b0);
    for (int i = 0; i < 4; i++) tick(1, 8'h0A + 8'(i), 0);
    tick(1, 8'h0E, 1);
    n = 0; first = EV_CODE;
    for (int i = 0; i < 8; i++) if (EV_VALID) begin n++; tick(0, 8'h00, 1); end
    chk("t5_fullpop_count", n, 4);
    chk("t5_fullpop_head", first, 8'h0B);

    // reset mid-prefix, device message
    tick(1, 8'hE0, 1);
    do_reset();
    tick(1, 8'h1C, 1);
    chk("t6_after_rst", {EV_VALID, EV_PAUSE, EV_EXT, EV_BREAK, EV_CODE}, {4'b1000, 8'h1C});
    tick(0, 8'h00, 1);
    tick(1, 8'hAA, 1);
    chk("t6_dev", {DEV_MSG, EV_VALID}, 2'b10);
    tick(0, 8'h00, 1);
    chk("t6_dev_end", DEV_MSG, 1'b0);

    // random streams
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] b;
      if ($urandom_range(0, 599) == 0) do_reset();
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      tick($urandom_range(0, 1) == 1, b, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_code_decoder.md
# ps2_code_decoder

Decodes the byte stream from the serial keyboard receiver (`NEW_CODE` strobe plus `CODE[7:0]`) into key events with make/break, extended and pause qualifiers. It tracks the modifier state and buffers events in a small FIFO with a valid/ready handshake for the consumer. It sits directly downstream of the receiver top level, in the same `CLK` domain.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; power of 2, at least 2.
- `CLK`  in  1: system clock; all logic is on the rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `NEW_CODE`  in  1: one-cycle strobe; `CODE` is valid in that cycle.
- `CODE`  in  8: received byte.
- `EV_VALID`  out  1: the FIFO is not empty; the head event is presented.
- `EV_READY`  in  1: the consumer accepts the head event when `EV_VALID` is high.
- `EV_CODE`  out  8: key code of the head event.
- `EV_BREAK`  out  1: the head event is a key release.
- `EV_EXT`  out  1: the head event carried the E0 prefix.
- `EV_PAUSE`  out  1: the head event is the Pause key.
- `MODS`  out  4: modifier state; [0] shift, [1] ctrl, [2] alt, [3] caps-lock latch.
- `DEV_MSG`  out  1: one-cycle pulse when a device message byte is received.
- `OVERFLOW`  out  1: sticky flag; an event was dropped because the FIFO was full.

## Operation
- Device message bytes are 00, AA, EE, FA, FE and FF. In any state except PAUSE_SKIP, such a byte:
  - pulses `DEV_MSG`;
  - produces no event;
  - returns the FSM to IDLE.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE_SKIP. Transitions are evaluated only when `NEW_CODE`=1.
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - E1 goes to PAUSE_SKIP and loads the skip counter with 7.
  - Any other byte emits a make event (brk=0, ext=0) and stays in IDLE.
- EXT:
  - F0 goes to EXT_BRK.
  - E0 stays in EXT.
  - Any other byte emits a make event with ext=1 and goes to IDLE.
- BRK, EXT_BRK:
  - E0, E1 or F0 abandons the pending sequence and is processed as if the FSM were in IDLE.
  - Any other byte emits a break event (ext=1 in EXT_BRK) and goes to IDLE.
- PAUSE_SKIP: every byte decrements the counter, regardless of its value. When the counter reaches 0, it emits {pause=1, ext=1, brk=0, code=77} and goes to IDLE.
- Extended 12 and extended 59 (fake shifts) are discarded. They produce no FIFO write and no change to `MODS`.
- Modifier tracking:
  - Internal held flags are kept for left shift 12, right shift 59, left ctrl 14, right ctrl E0 14, left alt 11 and right alt E0 11.
  - `MODS[0]` is the OR of the two shift flags, `MODS[1]` the OR of the ctrl flags, `MODS[2]` the OR of the alt flags.
  - `MODS[3]` toggles on a make of 58 only when caps is not already held. Typematic repeats do not toggle it.
  - A break of 58 clears the caps-held flag.
  - `MODS` updates even when the event itself is dropped by a full FIFO.
- FIFO:
  - Each entry is 11 bits: {pause, ext, brk, code}.
  - The FIFO is first-word fall-through; the head is always driven on the `EV_*` outputs.
  - A pop occurs when `EV_VALID` & `EV_READY`.
  - A push while full without a simultaneous pop drops the event and sets `OVERFLOW`.
  - A push while full with a simultaneous pop is accepted.

## Timing
- `NEW_CODE` is sampled at edge k. The state, `MODS`, the FIFO write and `DEV_MSG` all take effect at edge k.
- Latency: if the FIFO was empty, `EV_VALID`=1 in the cycle after edge k, i.e. 1 cycle. `DEV_MSG` is high for exactly that one cycle.
- Back-to-back `NEW_CODE` strobes on consecutive cycles are fully supported.
- The pop at edge j exposes the next entry after edge j. `EV_VALID` deasserts after the last pop.
- The `EV_*` outputs hold stable while `EV_VALID`=1 and `EV_READY`=0.
- Reset (`RST`=0) takes effect immediately and asynchronously:
  - FSM to IDLE; skip counter, held flags and `MODS` to 0;
  - FIFO empty; `EV_VALID`, `EV_CODE`, `EV_BREAK`, `EV_EXT`, `EV_PAUSE`, `DEV_MSG` and `OVERFLOW` all 0.
- Reset during a sequence discards any partial prefix state.

## Test plan
- 1C, then F0 1C with `EV_READY`=1 -> two events: {1C, brk0, ext0} one cycle after the first strobe, then {1C, brk1, ext0}.
- E0 14, then 12, 59, F0 12 -> `MODS`=4'b0011. Then E0 F0 14 -> `MODS`=4'b0001. E0 75 -> event {75, ext1}.
- E1 14 77 E1 F0 14 F0 77 sent back-to-back -> exactly one event {77, pause1, ext1, brk0}; `MODS` unchanged.
- 58 58 F0 58 58 -> `MODS[3]` is 1 after the first 58 and 0 after the final 58. E0 12 E0 7C -> only the event {7C, ext1}.
- `EV_READY`=0, five make codes 01..05 with `FIFO_DEPTH`=4 -> 01..04 held, `OVERFLOW`=1. Then `EV_READY`=1 -> drains in order 01, 02, 03, 04. A full FIFO with a simultaneous pop and push keeps the count at 4.
- E0, then `RST` pulsed low, then 1C -> {1C, ext0}. AA -> `DEV_MSG` high for one cycle and `EV_VALID` stays 0.
